// File: rtl/bus_fifo_reader.sv
// bus_fifo_reader: drains a registered-empty FIFO through a 2-entry skid buffer onto an arbitrated bursting bus
//
// Ports:
//   clk, rstn      clock and asynchronous active-low reset
//   fifo_rd_data   FIFO read word, valid the cycle after fifo_rd_en
//   fifo_empty     FIFO empty flag, registered, lags the occupancy by one cycle
//   fifo_rd_en     FIFO pop strobe
//   bus_req        request to the bus arbiter
//   bus_gnt        grant from the bus arbiter
//   out_data       bus word, taken from the skid head
//   out_valid      out_data valid
//   out_ready      bus accepts the word
//   out_last       final beat of the current burst, qualified by out_valid
module bus_fifo_reader #(
    parameter int DATA_LEN  = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [DATA_LEN-1:0] fifo_rd_data,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic [DATA_LEN-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
    state_t              state, state_nxt;
    logic [DATA_LEN-1:0] skid [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          cnt;
    logic                pop_q;
    logic                armed;
    logic [7:0]          beat;
    logic                take;
    // armed holds off popping until the first edge after reset release, so the
    // first pop lands no earlier than the second rising edge
    assign fifo_rd_en = armed && !fifo_empty && !pop_q && (({1'b0, cnt} + {2'b0, pop_q}) < 3'd2);
    assign out_data   = skid[rd_ptr];
    assign out_valid  = (state == XFER) && bus_gnt && (cnt != 2'd0);
    assign take       = out_valid && out_ready;
    // with no pop in flight the empty flag has caught up, so one held word and an
    // empty FIFO really means this is the last word available
    assign out_last   = out_valid && ((beat == 8'(BURST_LEN - 1)) ||
                                      (cnt == 2'd1 && !pop_q && fifo_empty));
    assign bus_req    = (state == REQ) || (state == XFER);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (cnt != 2'd0 || pop_q || !fifo_empty) ? REQ : IDLE;
            REQ:     state_nxt = bus_gnt ? XFER : REQ;
            XFER:    state_nxt = !bus_gnt ? REQ : (out_last && out_ready) ? IDLE : XFER;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            skid[0] <= '0;
            skid[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
            pop_q   <= 1'b0;
            armed   <= 1'b0;
            beat    <= 8'd0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            pop_q <= fifo_rd_en;
            if (pop_q) begin
                skid[wr_ptr] <= fifo_rd_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (take)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, pop_q} - {1'b0, take};
            // counter survives a grant drop (XFER->REQ) and restarts only via IDLE
            if (state == IDLE)
                beat <= 8'd0;
            else if (take)
                beat <= beat + 8'd1;
        end
    end
endmodule

// File: tb/tb_bus_fifo_reader.sv
// tb_bus_fifo_reader: directed bench for bus_fifo_reader with a lagging-empty FIFO model
module tb_bus_fifo_reader;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] fifo_rd_data = 16'h0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;

    int n_checks = 0;
    int n_fail   = 0;

    bus_fifo_reader #(.DATA_LEN(16), .BURST_LEN(8)) dut (
        .clk(clk), .rstn(rstn), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: flag registered from the pre-edge occupancy, so it lags pops by one cycle
    logic [15:0] q[$];
    always @(posedge clk) begin
        fifo_empty <= (q.size() == 0);
        if (fifo_rd_en) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_on_empty: got pop expected none");
            end else
                fifo_rd_data <= q.pop_front();
        end
    end

    // monitor: beats, last flags, pop legality, stall stability
    logic [15:0] got_q[$];
    logic [31:0] last_mask;
    int          nbeats, pops, beats, req_low, req_lim;
    logic        pop_prev, prev_hold;
    logic [15:0] hold_data;
    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            got_q.delete();
            last_mask = 0; nbeats = 0; pops = 0; beats = 0; req_low = 0;
            pop_prev = 0; prev_hold = 0; hold_data = 0;
        end else begin
            if (fifo_rd_en) begin
                chk("no_back_to_back_pop", 32'(pop_prev), 0);
                chk("pop_room", 32'(pops - beats >= 2), 0);
            end
            if (prev_hold)
                chk("stall_stable", {15'h0, out_valid, out_data}, {15'h0, 1'b1, hold_data});
            if (out_last)
                chk("last_qualified", 32'(out_valid), 1);
            if (!bus_req && nbeats > 0 && nbeats < req_lim)
                req_low++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (out_last) last_mask[nbeats] = 1'b1;
                nbeats++;
            end
            pops  += int'(fifo_rd_en);
            beats += int'(out_valid && out_ready);
            prev_hold = out_valid && !out_ready;
            hold_data = out_data;
            pop_prev  = fifo_rd_en;
        end
    end

    task automatic start(input int n, input logic [15:0] base, input logic [15:0] step);
        rstn = 1'b0; bus_gnt = 1'b0; out_ready = 1'b0; req_lim = 0;
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(16'(base + 16'(i) * step));
        repeat (3) @(negedge clk);
        #1 chk("reset_outputs", {12'h0, fifo_rd_en, bus_req, out_valid, out_last, out_data}, 0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int c = 0;
        while (nbeats < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(nbeats >= n), 1);
    endtask

    task automatic check_order(input string name, input int n, input logic [15:0] base, input logic [15:0] step);
        chk({name, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < got_q.size() && i < n; i++)
            chk({name, "_word"}, {16'h0, got_q[i]}, {16'h0, 16'(base + 16'(i) * step)});
    endtask

    typedef struct packed {
        logic        gnt, ready, rd_en, req, valid, last;
        logic [15:0] data;
    } vec_t;
    vec_t tbl[10];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // three words A,B,C: cycle-exact trace from reset release
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA0A0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hB1B1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hC2C2};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        start(3, 16'hA0A0, 16'h1111);
        for (int i = 0; i < 10; i++) begin
            bus_gnt = tbl[i].gnt; out_ready = tbl[i].ready;
            #1 chk($sformatf("abc_cycle%0d", i),
                   {12'h0, fifo_rd_en, bus_req, out_valid, out_last, tbl[i].valid ? out_data : 16'h0},
                   {12'h0, tbl[i].rd_en, tbl[i].req, tbl[i].valid, tbl[i].last, tbl[i].data});
            @(negedge clk);
        end
        check_order("abc", 3, 16'hA0A0, 16'h1111);

        // twenty words: bursts of 8, 8, 4 with one idle cycle between bursts
        start(20, 16'h3400, 16'h1);
        bus_gnt = 1'b1; out_ready = 1'b1; req_lim = 20;
        wait_beats(20, 300, "burst20_done");
        repeat (6) @(negedge clk);
        check_order("burst20", 20, 16'h3400, 16'h1);
        chk("burst20_last", last_mask, 32'h0008_8080);
        chk("burst20_req_gap", 32'(req_low), 2);

        // ready stall for five cycles after beat 3
        start(10, 16'h3500, 16'h1);
        bus_gnt = 1'b1; out_ready = 1'b1;
        wait_beats(3, 100, "stall_reach3");
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_fill", 32'(pops - beats), 2);
        chk("stall_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        wait_beats(10, 200, "stall_done");
        repeat (6) @(negedge clk);
        check_order("stall", 10, 16'h3500, 16'h1);
        chk("stall_last", last_mask, 32'h0000_0280);

        // grant dropped after beat 3 for four cycles; counter must carry over
        start(12, 16'h3600, 16'h1);
        bus_gnt = 1'b1; out_ready = 1'b1;
        wait_beats(3, 100, "gnt_reach3");
        bus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("ungranted_quiet", {30'h0, out_valid, bus_req}, 32'h1);
            @(negedge clk);
        end
        chk("ungranted_beats", 32'(nbeats), 3);
        bus_gnt = 1'b1;
        wait_beats(12, 200, "gnt_done");
        repeat (6) @(negedge clk);
        check_order("gnt", 12, 16'h3600, 16'h1);
        chk("gnt_last", last_mask, 32'h0000_0880);

        // single word: exactly one pop despite the lagging empty flag
        start(1, 16'h3700, 16'h1);
        bus_gnt = 1'b1; out_ready = 1'b1;
        repeat (15) @(negedge clk);
        chk("single_pops", 32'(pops), 1);
        check_order("single", 1, 16'h3700, 16'h1);
        chk("single_last", last_mask, 32'h1);

        // reset while the skid holds two words: they are discarded
        start(6, 16'h3800, 16'h1);
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("midreset_fill", 32'(pops - beats), 2);
        rstn = 1'b0;
        #1 chk("midreset_outputs", {12'h0, fifo_rd_en, bus_req, out_valid, out_last, out_data}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1 chk("release_no_pop", 32'(fifo_rd_en), 0);
        bus_gnt = 1'b1;
        wait_beats(4, 100, "midreset_done");
        repeat (8) @(negedge clk);
        check_order("midreset", 4, 16'h3802, 16'h1);
        chk("midreset_last", last_mask, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_fifo_reader.md
BUS_FIFO_READER -- requirements
Module: bus_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_LEN, default 16, word width shared with the bus FIFO.
REQ-002 SHALL have parameter BURST_LEN, default 8, maximum beats per grant (range 1..255).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fifo_rd_data  input  DATA_LEN  FIFO read word, valid the cycle after fifo_rd_en.
REQ-006 SHALL have port fifo_empty  input  1  FIFO registered empty flag, lags occupancy by one cycle.
REQ-007 SHALL have port fifo_rd_en  output  1  FIFO pop strobe.
REQ-008 SHALL have port bus_req  output  1  request to the bus arbiter.
REQ-009 SHALL have port bus_gnt  input  1  grant from the bus arbiter.
REQ-010 SHALL have port out_data  output  DATA_LEN  bus word.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  bus accepts a word.
REQ-013 SHALL have port out_last  output  1  final beat of the current burst, qualified by out_valid.

Function
REQ-014 SHALL contain a 2-entry skid buffer (FIFO order) between fifo_rd_data and out_data.
REQ-015 SHALL assert fifo_rd_en only when all hold: fifo_empty==0, no pop in the previous cycle, and (skid occupancy + pops in flight) < 2.
REQ-016 SHALL, because of the lagging empty flag, never pop on consecutive cycles; the sustained rate is 1 word per 2 cycles.
REQ-017 SHALL write fifo_rd_data into the skid buffer exactly one cycle after each fifo_rd_en and at no other time.
REQ-018 SHALL drive out_data from the skid head, and out_valid = (state==XFER) && bus_gnt && skid non-empty.
REQ-019 SHALL count a beat on out_valid && out_ready and pop the skid head in that cycle; a simultaneous skid write and read SHALL be legal.
REQ-020 SHALL keep out_data and out_valid stable while out_valid==1 and out_ready==0.
REQ-021 SHALL implement FSM states IDLE, REQ, XFER.
REQ-022 IDLE->REQ SHALL occur when the skid is non-empty, a pop is in flight, or fifo_empty==0.
REQ-023 REQ SHALL drive bus_req=1; REQ->XFER SHALL occur on bus_gnt==1.
REQ-024 XFER SHALL drive bus_req=1 and keep an 8-bit beat counter, cleared on entry from IDLE.
REQ-025 out_last SHALL be 1 on a valid beat when beat counter==BURST_LEN-1, or when the skid holds exactly one word, no pop is in flight and fifo_empty==1.
REQ-026 XFER->IDLE SHALL occur the cycle after the out_last beat; bus_req SHALL be 0 in that next cycle.
REQ-027 If bus_gnt drops during XFER, out_valid SHALL be 0 from that cycle, FSM->REQ, and the beat counter SHALL be retained; resumption counts toward the same burst.
REQ-028 In XFER with an empty skid and no last beat yet, the FSM SHALL hold XFER and keep bus_req=1 until data arrives.
REQ-029 Pops SHALL continue in every state, including IDLE, subject to REQ-015.
REQ-030 Words SHALL leave in exactly FIFO order with no loss or duplication.

Reset
REQ-031 On rstn==0: state=IDLE; skid empty; pop-in-flight cleared; beat counter=0; fifo_rd_en=0, bus_req=0, out_valid=0, out_last=0, out_data=0.
REQ-032 Reset asserted mid-burst SHALL discard skid contents and in-flight data; after release, the first pop SHALL occur no earlier than the second rising edge.

Verification
REQ-033 FIFO preloaded with 3 words A,B,C, gnt on first req, ready=1 -> pops 2 cycles apart; beats A,B,C; out_last on C; bus_req drops after C.
REQ-034 FIFO holds 20 words, BURST_LEN=8, gnt always granted -> bursts of 8,8,4; out_last on beats 8, 16 and 20; bus_req low for 1 cycle between bursts.
REQ-035 out_ready=0 for 5 cycles mid-burst -> out_data/out_valid stable; at most 2 words skid-held; no fifo_rd_en once skid+in-flight=2; order intact.
REQ-036 bus_gnt dropped after beat 3 of 8, regranted 4 cycles later -> out_valid=0 while ungranted; resumes at beat 4; out_last on beat 8.
REQ-037 FIFO with 1 word, fifo_empty lagging -> exactly one fifo_rd_en, no second pop; single beat with out_last=1.
REQ-038 rstn pulsed low while skid holds 2 words -> all outputs 0 at once; no stale word emitted after release.
